// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: round-robin scheduler sharing one registered adder among N requesters, returning ID-tagged results
//   clk, reset                  : rising-edge clock, synchronous active-high reset
//   req_valid/req_a/req_b/req_ci : per-requester operands, requester i at [i*W +: W]
//   req_ready                    : one-hot grant, transfer on req_valid & req_ready
//   add_a/add_b/add_ci           : operands to the shared adder, zero when nothing is granted
//   add_s/add_co                 : adder result, ADD_LAT cycles after its operands
//   rsp_valid/rsp_id/rsp_s/rsp_co : registered one-cycle result pulse with owner index
//   busy                         : any operation in flight in the tag pipeline
module add_rr_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int ADD_LAT = 1,
  parameter int IDW     = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_ci,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_ci,
  input  logic [W-1:0]   add_s,
  input  logic           add_co,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_s,
  output logic           rsp_co,
  output logic           busy
);
  logic [IDW-1:0]     ptr_q, ptr_d, gnt_id;
  logic               gnt_vld;
  logic [ADD_LAT-1:0] vld_q;
  logic [IDW-1:0]     id_q [ADD_LAT];
  logic               rsp_valid_q, rsp_co_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [W-1:0]       rsp_s_q;

  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v >= N ? v - N : v);
  endfunction

  // scanning from the far end lets the requester closest to ptr win
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = N - 1; k >= 0; k--)
      if (!reset && req_valid[wrap(int'(ptr_q) + k)]) begin
        gnt_vld = 1'b1;
        gnt_id  = wrap(int'(ptr_q) + k);
      end
  end

  assign ptr_d     = gnt_vld ? wrap(int'(gnt_id) + 1) : ptr_q;
  assign req_ready = gnt_vld ? N'(1) << gnt_id : '0;
  assign add_a     = gnt_vld ? req_a[gnt_id*W +: W] : '0;
  assign add_b     = gnt_vld ? req_b[gnt_id*W +: W] : '0;
  assign add_ci    = gnt_vld ? req_ci[gnt_id] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      vld_q       <= '0;
      for (int i = 0; i < ADD_LAT; i++) id_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_co_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= gnt_vld;
      id_q[0]  <= gnt_id;
      for (int i = 1; i < ADD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
      rsp_valid_q <= vld_q[ADD_LAT-1];
      if (vld_q[ADD_LAT-1]) begin
        rsp_id_q <= id_q[ADD_LAT-1];
        rsp_s_q  <= add_s;
        rsp_co_q <= add_co;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_co    = rsp_co_q;
  assign busy      = |vld_q;
endmodule

// File: tb/tb_add_rr_arbiter.sv
// tb_add_rr_arbiter: scoreboard bench driving ADD_LAT=1 and ADD_LAT=3 instances with identical stimulus
module tb_add_rr_arbiter;
  localparam int N = 4, W = 32, IDW = 2;
  typedef struct {
    int             cyc;
    logic [IDW-1:0] id;
    logic [W-1:0]   s;
    logic           co;
  } exp_t;
  logic           clk = 1'b0, reset = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ci = '0, pend = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   rdy [2];
  logic [W-1:0]   aa [2], bb [2], ss [2], rs [2];
  logic           ci_o [2], sco [2], rv [2], rco [2], bz [2];
  logic [IDW-1:0] rid [2];
  exp_t           sbq [2][$];
  int cyc = 0, vectors = 0, miscompares = 0, mptr = 0, last_gnt = -100, last_rst = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = g ? 3 : 1;
    logic [W:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= {1'b0, aa[g]} + {1'b0, bb[g]} + (W+1)'(ci_o[g]);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ss[g]  = pipe[L-1][W-1:0];
    assign sco[g] = pipe[L-1][W];
    add_rr_arbiter #(.N(N), .W(W), .ADD_LAT(L), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ci(req_ci), .req_ready(rdy[g]), .add_a(aa[g]), .add_b(bb[g]), .add_ci(ci_o[g]),
      .add_s(ss[g]), .add_co(sco[g]), .rsp_valid(rv[g]), .rsp_id(rid[g]), .rsp_s(rs[g]),
      .rsp_co(rco[g]), .busy(bz[g]));
  end

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lat%0d: got %0h expected %0h at cycle %0d", name, g ? 3 : 1, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int lat;
    for (int g = 0; g < 2; g++) begin
      lat = g ? 3 : 1;
      if (rv[g]) begin
        if (sbq[g].size() == 0) chk("rsp_unexpected", g, 64'(rv[g]), 64'(0));
        else begin
          e = sbq[g].pop_front();
          chk("rsp_latency", g, 64'(cyc), 64'(e.cyc + lat + 1));
          chk("rsp_id", g, 64'(rid[g]), 64'(e.id));
          chk("rsp_s", g, 64'(rs[g]), 64'(e.s));
          chk("rsp_co", g, 64'(rco[g]), 64'(e.co));
        end
      end else if (sbq[g].size() > 0 && sbq[g][0].cyc + lat + 1 <= cyc) begin
        chk("rsp_missing", g, 64'(rv[g]), 64'(1));
        void'(sbq[g].pop_front());
      end
    end
  end

  // reference: first valid requester at or after the pointer, sum by plain wide addition
  task automatic eval();
    int gid;
    logic [W:0] sum;
    logic [N-1:0] er;
    logic [W-1:0] ea, eb;
    logic ec;
    exp_t e;
    #1;
    gid = -1;
    if (!reset)
      for (int k = 0; k < N; k++)
        if (gid < 0 && req_valid[(mptr + k) % N]) gid = (mptr + k) % N;
    er = '0; ea = '0; eb = '0; ec = 1'b0; sum = '0;
    if (gid >= 0) begin
      er  = N'(1) << gid;
      ea  = req_a[gid*W +: W];
      eb  = req_b[gid*W +: W];
      ec  = req_ci[gid];
      sum = {1'b0, ea} + {1'b0, eb} + (W+1)'(ec);
    end
    for (int g = 0; g < 2; g++) begin
      chk("req_ready", g, 64'(rdy[g]), 64'(er));
      chk("add_a", g, 64'(aa[g]), 64'(ea));
      chk("add_b", g, 64'(bb[g]), 64'(eb));
      chk("add_ci", g, 64'(ci_o[g]), 64'(ec));
      chk("busy", g, 64'(bz[g]), 64'(last_gnt > last_rst && cyc - last_gnt <= (g ? 3 : 1)));
    end
    pend = req_valid & ~er;
    if (gid >= 0) begin
      e.cyc = cyc; e.id = IDW'(gid); e.s = sum[W-1:0]; e.co = sum[W];
      sbq[0].push_back(e);
      sbq[1].push_back(e);
      last_gnt = cyc;
      mptr = (gid + 1) % N;
    end
    if (reset) begin
      sbq[0].delete();
      sbq[1].delete();
      mptr = 0;
      last_rst = cyc;
    end
  endtask

  task automatic next();
    @(negedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_ci[i] = c;
  endtask

  task automatic step(input logic [N-1:0] v, input logic r);
    req_valid = v;
    reset = r;
    eval();
  endtask

  task automatic idle(input int n);
    repeat (n) begin next(); step('0, 1'b0); end
  endtask

  task automatic hold_chk(input string name, input logic [IDW-1:0] id, input logic [W-1:0] s, input logic co);
    for (int g = 0; g < 2; g++) begin
      chk({name, "_id"}, g, 64'(rid[g]), 64'(id));
      chk({name, "_s"}, g, 64'(rs[g]), 64'(s));
      chk({name, "_co"}, g, 64'(rco[g]), 64'(co));
    end
  endtask

  initial begin
    repeat (3) begin next(); step('0, 1'b1); end
    next(); step('0, 1'b0);
    for (int g = 0; g < 2; g++) chk("reset_rsp_valid", g, 64'(rv[g]), 64'(0));
    hold_chk("reset", '0, '0, 1'b0);
    next(); set_op(2, 32'd38297, 32'd126625, 1'b0); step(4'b0100, 1'b0);
    idle(5);
    hold_chk("t1_hold", 2'd2, 32'd164922, 1'b0);
    next(); set_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0); step(4'b0001, 1'b0);
    next(); set_op(0, 32'd0, 32'hFFFF_FFFF, 1'b1); step(4'b0001, 1'b0);
    idle(5);
    hold_chk("t2_hold", 2'd0, 32'd0, 1'b1);
    next(); step('0, 1'b1);
    next();
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 1'($urandom));
    step(4'b1111, 1'b0);
    repeat (5) begin next(); step(4'b1111, 1'b0); end
    idle(5);
    next(); step('0, 1'b1);
    next(); step(4'b0010, 1'b0);
    next(); step(4'b1010, 1'b0);
    next(); step(4'b1010, 1'b0);
    next(); step(4'b1111, 1'b0);
    idle(5);
    next(); step(4'b0011, 1'b0);
    next(); step(4'b0011, 1'b0);
    next(); step('0, 1'b1);
    next(); step(4'b0010, 1'b0);
    idle(10);
    for (int n = 0; n < 600; n++) begin
      next();
      for (int i = 0; i < N; i++)
        if (!pend[i])
          set_op(i, $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : W'($urandom), W'($urandom), 1'($urandom));
      step(N'($urandom), $urandom_range(0, 49) == 0);
    end
    idle(6);
    for (int g = 0; g < 2; g++) chk("drain", g, 64'(sbq[g].size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
